// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the 8-by-4 restoring divider.
// The requester drives start and the operands through the master modport.
// The divider drives the handshake status and the results through the slave modport.
interface divider_if #(
  parameter int VW = 4,
  parameter int DW = 2 * VW
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/divider_8by4.sv
// Sequential restoring divider: an 8-bit unsigned dividend divided by a 4-bit
// unsigned divisor gives an 8-bit quotient and a 4-bit remainder.
// The divider resolves one quotient bit per clock and uses a start/done handshake.
// A zero divisor gives all-ones results and raises dbz. It takes no shift cycles.
module divider_8by4 #(
  parameter int VW = 4,
  parameter int DW = 2 * VW
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] q_sh;       // dividend bits shift out the top, quotient bits enter the bottom
  logic [VW-1:0] d_r;        // captured divisor
  logic [VW-1:0] p;          // partial remainder
  logic [CW-1:0] cnt;        // iterations left, minus one
  logic          ready_r;
  logic          done_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          dbz_r;

  // The shifted trial value t holds VW+1 bits. After each compare the partial
  // remainder is always below d_r, so VW bits are enough to store it.
  // If t[VW] is set, t is at least 2^VW, which is larger than any divisor.
  // In that case the low-bit difference is exact modulo 2^VW and also fits in VW bits.
  logic [VW:0]   t;
  logic          q_bit;
  logic [VW-1:0] p_nxt;
  logic [DW-1:0] q_nxt;

  // One restoring step: trial subtract, then keep the difference or restore.
  always_comb begin
    t     = {p, q_sh[DW-1]};
    q_bit = t[VW] || (t[VW-1:0] >= d_r);
    p_nxt = q_bit ? (t[VW-1:0] - d_r) : t[VW-1:0];
    q_nxt = {q_sh[DW-2:0], q_bit};
  end

  // Control FSM and datapath registers. Every output is registered.
  // NOTE: sequential state uses non-blocking assignments only. This way every
  // register samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working registers are cleared with the results. Nothing reads
      // them outside RUN, but they then start from a known value in simulation.
      state       <= IDLE;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      cnt         <= '0;
      q_sh        <= '0;
      d_r         <= '0;
      p           <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_sh    <= bus.dividend;
            d_r     <= bus.divisor;
            p       <= '0;
            cnt     <= CW'(DW - 1);
            ready_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (d_r == '0) begin
            // A zero divisor spends its first cycle here without shifting.
            // This places the done pulse one cycle after the edge that follows acceptance.
            quotient_r  <= '1;
            remainder_r <= '1;
            dbz_r       <= 1'b1;
            done_r      <= 1'b1;
            state       <= FIN;
          end else begin
            q_sh <= q_nxt;
            p    <= p_nxt;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient_r  <= q_nxt;
              remainder_r <= p_nxt;
              dbz_r       <= 1'b0;
              done_r      <= 1'b1;
              state       <= FIN;
            end
          end
        end
        FIN: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dbz       = dbz_r;

endmodule

// File: tb/tb_divider_8by4.sv
// Directed bench for divider_8by4. Each scenario task drives its own stimulus
// and compares the outputs against values the bench computes by hand.
// Inputs change, and outputs are sampled, 1 ns after each rising edge.
module tb_divider_8by4;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  divider_if #(.VW(4)) bus ();

  divider_8by4 #(.VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one divide from IDLE. lat is the number of edges after acceptance up
  // to the done cycle, or -1 if no done appears within the bound. The results
  // are sampled in the done cycle. One more edge is taken afterwards, and the
  // done and ready values seen then are returned as well.
  task automatic do_div(input logic [7:0] n, input logic [3:0] d, output int lat,
                        output logic [7:0] q, output logic [3:0] r, output logic z,
                        output logic done_after, output logic ready_after);
    bus.dividend = n;
    bus.divisor  = d;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    q = 'x; r = 'x; z = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        q = bus.quotient;
        r = bus.remainder;
        z = bus.dbz;
        break;
      end
    end
    tick();
    done_after  = bus.done;
    ready_after = bus.ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.quotient !== 8'd0) begin n_bad++; $display("FAIL reset_quotient got=%0d want=0", bus.quotient); end
    n_cmp++; if (bus.remainder !== 4'd0) begin n_bad++; $display("FAIL reset_remainder got=%0d want=0", bus.remainder); end
    n_cmp++; if (bus.dbz !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got=%b want=0", bus.dbz); end
  endtask

  task automatic test_basic;
    int lat; logic [7:0] q; logic [3:0] r; logic z, da, ra;
    do_div(8'd200, 4'd13, lat, q, r, z, da, ra);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got=%0d want=8 edges after accept", lat); end
    n_cmp++; if (q !== 8'd15) begin n_bad++; $display("FAIL basic_quotient got=%0d want=15", q); end
    n_cmp++; if (r !== 4'd5) begin n_bad++; $display("FAIL basic_remainder got=%0d want=5", r); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL basic_dbz got=%b want=0", z); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL basic_done_single got=%b want=0", da); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL basic_ready_after got=%b want=1", ra); end
    n_cmp++; if (bus.quotient !== 8'd15 || bus.remainder !== 4'd5) begin
      n_bad++; $display("FAIL basic_hold got=%0d r%0d want=15 r5", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] nv [3];
    logic [3:0] dv [3];
    logic [7:0] qv [3];
    logic [3:0] rv [3];
    int k, last;
    logic prev_done;
    nv = '{8'd255, 8'd7, 8'd225};
    dv = '{4'd1, 4'd9, 4'd15};
    qv = '{8'd255, 8'd0, 8'd15};
    rv = '{4'd0, 4'd7, 4'd0};
    k = 0; last = 0; prev_done = 1'b0;
    bus.dividend = nv[0];
    bus.divisor  = dv[0];
    bus.start    = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
      tick();
      if (bus.done === 1'b1) begin
        n_cmp++; if (prev_done !== 1'b0) begin n_bad++; $display("FAIL b2b_double_done op=%0d got=1 want=0", k); end
        n_cmp++; if (bus.quotient !== qv[k] || bus.remainder !== rv[k] || bus.dbz !== 1'b0) begin
          n_bad++; $display("FAIL b2b_result op=%0d got=%0d r%0d z%b want=%0d r%0d z0",
                            k, bus.quotient, bus.remainder, bus.dbz, qv[k], rv[k]);
        end
        n_cmp++; if ((k == 0 ? cyc : cyc - last) !== (k == 0 ? 8 : 10)) begin
          n_bad++; $display("FAIL b2b_spacing op=%0d got=%0d want=%0d", k, (k == 0 ? cyc : cyc - last), (k == 0 ? 8 : 10));
        end
        last = cyc;
        k++;
        if (k < 3) begin
          bus.dividend = nv[k];
          bus.divisor  = dv[k];
        end else begin
          bus.start = 1'b0;
        end
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", k); end
    tick();
    tick();
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready got=%b want=1", bus.ready); end
  endtask

  task automatic test_dbz;
    int lat; logic [7:0] q; logic [3:0] r; logic z, da, ra;
    do_div(8'd100, 4'd0, lat, q, r, z, da, ra);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz_latency got=%0d want=1 edge after accept", lat); end
    n_cmp++; if (q !== 8'hFF) begin n_bad++; $display("FAIL dbz_quotient got=%h want=ff", q); end
    n_cmp++; if (r !== 4'hF) begin n_bad++; $display("FAIL dbz_remainder got=%h want=f", r); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got=%b want=1", z); end
    n_cmp++; if (ra !== 1'b1 || da !== 1'b0) begin n_bad++; $display("FAIL dbz_after got=ready%b done%b want=ready1 done0", ra, da); end
    n_cmp++; if (bus.dbz !== 1'b1) begin n_bad++; $display("FAIL dbz_hold got=%b want=1", bus.dbz); end
    do_div(8'd100, 4'd10, lat, q, r, z, da, ra);
    n_cmp++; if (lat !== 8 || q !== 8'd10 || r !== 4'd0 || z !== 1'b0) begin
      n_bad++; $display("FAIL dbz_recover got=lat%0d %0d r%0d z%b want=lat8 10 r0 z0", lat, q, r, z);
    end
  endtask

  task automatic test_ignore_inputs;
    int lat;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd13;
    bus.start    = 1'b1;
    tick();
    bus.dividend = 8'd50;
    bus.divisor  = 4'd3;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) bus.start = 1'b0;
      tick();
      n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL ignore_ready cyc=%0d got=%b want=0", i, bus.ready); end
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL ignore_latency got=%0d want=8", lat); end
    n_cmp++; if (bus.quotient !== 8'd15 || bus.remainder !== 4'd5) begin
      n_bad++; $display("FAIL ignore_result got=%0d r%0d want=15 r5", bus.quotient, bus.remainder);
    end
    tick();
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL ignore_ready_after got=%b want=1", bus.ready); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] q; logic [3:0] r; logic z, da, ra;
    logic seen_done;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd13;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", bus.ready); end
    n_cmp++; if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0 || bus.dbz !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_results got=%0d r%0d z%b want=0 r0 z0", bus.quotient, bus.remainder, bus.dbz);
    end
    seen_done = bus.done;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got=%b want=0", seen_done); end
    do_div(8'd81, 4'd9, lat, q, r, z, da, ra);
    n_cmp++; if (lat !== 8 || q !== 8'd9 || r !== 4'd0 || z !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_fresh got=lat%0d %0d r%0d z%b want=lat8 9 r0 z0", lat, q, r, z);
    end
  endtask

  task automatic test_products;
    int lat; logic [7:0] q; logic [3:0] r; logic z, da, ra;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        do_div(8'(a * b), 4'(b), lat, q, r, z, da, ra);
        n_cmp++; if (lat !== 8 || q !== 8'(a) || r !== 4'd0 || z !== 1'b0) begin
          n_bad++; $display("FAIL product %0d/%0d got=lat%0d %0d r%0d z%b want=lat8 %0d r0 z0", a * b, b, lat, q, r, z, a);
        end
      end
    end
  endtask

  task automatic test_all_dividends;
    int lat; logic [7:0] q; logic [3:0] r; logic z, da, ra;
    for (int d = 1; d <= 15; d++) begin
      for (int n = 0; n <= 255; n++) begin
        do_div(8'(n), 4'(d), lat, q, r, z, da, ra);
        n_cmp++; if (lat !== 8 || q !== 8'(n / d) || r !== 4'(n % d) || z !== 1'b0) begin
          n_bad++; $display("FAIL sweep %0d/%0d got=lat%0d %0d r%0d z%b want=lat8 %0d r%0d z0", n, d, lat, q, r, z, n / d, n % d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_dbz();
    test_ignore_inputs();
    test_reset_mid();
    test_products();
    test_all_dividends();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
